backprop_collector: RTL and testbench
=====================================

# backprop_collector

Gathers the per-input error vectors (`backpropChange`) emitted by the learning neurons of one layer and sums them lane-by-lane into the scalar backprop error each upstream neuron expects on its `backprop` input. It is the receiving end of the backprop path. Downstream neurons hand over their change vectors one at a time through a valid/ready handshake, and the collector presents the completed per-upstream-neuron error sums with a done flag. One instance sits between every pair of adjacent layers.

## Interface
Parameters:
- `N_INPUTS`, default 32: lanes per change vector; equals upstream layer width.
- `N_SOURCES`, default 8: maximum number of downstream neurons contributing per epoch.
- `CW`, default `$clog2(N_SOURCES+1)`: width of source counters.

Ports:
- `bc_clock`, input, 1: the single clock. All state updates on posedge.
- `bc_reset`, input, 1: asynchronous, active-high reset.
- `bc_start`, input, 1: begins a new collection epoch.
- `bc_num_sources`, input, CW: number of vectors to collect. Sampled only when `bc_start` is high.
- `bc_enabled`, input, N_INPUTS: lane mask. Lane k is summed only if bit k is 1. Sampled per accepted vector.
- `bc_change_valid`, input, 1: `bc_change` holds a vector.
- `bc_change[N_INPUTS-1:0]`, input, real: one downstream neuron's `backpropChange` vector.
- `bc_change_ready`, output, 1: collector accepts a vector this cycle.
- `bc_backprop[N_INPUTS-1:0]`, output, real: accumulated error per upstream neuron.
- `bc_count`, output, CW: vectors accepted in the current epoch.
- `bc_busy`, output, 1: high in COLLECT.
- `bc_done`, output, 1: high in DONE; `bc_backprop` is final.

## Operation
States are IDLE, COLLECT and DONE. Reset enters IDLE.

Reset values:
- All `bc_backprop` lanes = 0.0.
- `bc_count` = 0; `bc_busy`, `bc_done`, `bc_change_ready` = 0.
- Latched source target = 0.

Transitions:
- **IDLE or DONE, `bc_start`=1:**
  - Clear all accumulators to 0.0, `bc_count` to 0, and latch `bc_num_sources`.
  - If the latched value is 0, go to DONE. Otherwise go to COLLECT.
- **COLLECT, `bc_start`=1:**
  - Abort the epoch: clear, relatch and re-enter as above.
  - A `bc_change_valid` in the same cycle is not accepted, and its data is discarded.
- **COLLECT, `bc_change_valid` & `bc_change_ready`:**
  - For each lane k, `acc[k] += bc_enabled[k] ? bc_change[k] : 0.0`.
  - Increment `bc_count`.
  - If the new count equals the target, go to DONE.
- **DONE:**
  - Accumulators and `bc_count` hold.
  - Stays in DONE until `bc_start` or reset.

Ready and handshake rules:
- `bc_change_ready` = (state == COLLECT), decoded from the state register only. It does not depend on `bc_change_valid`.
- Valid asserted in IDLE or DONE is ignored. No accumulation happens and no error is flagged.
- `bc_num_sources` > `N_SOURCES` is clamped to `N_SOURCES` at latch time.

Outputs:
- `bc_backprop` drives the accumulator registers directly.
- During COLLECT it shows partial sums. Consumers sample it only while `bc_done`=1.

Arithmetic:
- IEEE double (`real`), summed in acceptance order.
- No saturation and no scaling. The training ratio is applied by the consuming neuron, not here.

## Timing
- Accept latency: the vector accepted at posedge t is reflected in `bc_backprop` and `bc_count` after posedge t.
- Start to ready: `bc_start` sampled at posedge t gives `bc_change_ready`=1 after t, for a nonzero target.
- Back-to-back acceptance is allowed: one vector per cycle, zero bubbles.
- Last accept to done: the final accept at posedge t gives `bc_done`=1 and `bc_change_ready`=0 after t. The same edge fixes the sums.
- Zero sources: `bc_start` at t gives `bc_done`=1 after t, with all lanes 0.0.
- Neuron weight latching uses negedge, so `bc_backprop` is stable for a half cycle before any consuming neuron latches it.
- Reset mid-COLLECT: all outputs go to reset values immediately, without waiting for a clock edge. Partial sums are lost.
- Reset release: the first posedge after deassertion may accept `bc_start`.

## Test plan
- **Basic sum:** start with `num_sources`=3, all lanes enabled. Feed lane 0 = 0.5, -0.25, 1.0 and lane 5 = 2.0, 2.0, 2.0 on consecutive cycles. Required: `bc_done` after the 3rd accept, lane 0 = 1.25, lane 5 = 6.0, all other lanes 0.0, `bc_count`=3.
- **Stalled handshake:** `num_sources`=2, valid pulsed with idle gaps of 1 and 3 cycles. Required: exactly 2 accepts, and sums match a gap-free run.
- **Mask:** `bc_enabled`=32'h0000_0001, one vector of all 1.0. Required: lane 0 = 1.0, lanes 1-31 = 0.0.
- **Boundaries:**
  - `num_sources`=0 gives `bc_done` one cycle after start, all lanes 0.0, and `bc_change_ready` never high.
  - `num_sources`=15 with `N_SOURCES`=8 finishes after 8 accepts.
- **Restart and ignored valid:**
  - `bc_start` during COLLECT after 1 of 3 vectors, with valid high in the same cycle. Required: accumulators 0.0, `bc_count`=0, and that vector is not counted.
  - Valid asserted in DONE leaves sums unchanged.
- **Async reset:** assert `bc_reset` between edges mid-COLLECT. Required: `bc_busy`=0, lanes 0.0 and `bc_count`=0 before the next posedge. After release, IDLE ignores valid until `bc_start`.

Source files
------------

// File: rtl/backprop_collector.sv
// Sums the backprop change vectors from the neurons of one layer into a
// per-upstream-neuron error. Vectors arrive through a valid/ready handshake.
module backprop_collector #(
  parameter int N_INPUTS  = 32,
  parameter int N_SOURCES = 8,
  parameter int CW        = $clog2(N_SOURCES + 1)
) (
  input  logic                bc_clock,
  input  logic                bc_reset,
  input  logic                bc_start,
  input  logic [CW-1:0]       bc_num_sources,
  input  logic [N_INPUTS-1:0] bc_enabled,
  input  logic                bc_change_valid,
  input  real                 bc_change [N_INPUTS-1:0],
  output logic                bc_change_ready,
  output real                 bc_backprop [N_INPUTS-1:0],
  output logic [CW-1:0]       bc_count,
  output logic                bc_busy,
  output logic                bc_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] target_q;
  real           acc_q [N_INPUTS-1:0];

  logic [CW-1:0] target_d;
  logic [CW-1:0] count_d;
  logic          accept;

  // Requests above the physical source limit are clamped when latched.
  always_comb begin
    target_d = bc_num_sources;
    if (bc_num_sources > CW'(N_SOURCES)) target_d = CW'(N_SOURCES);
  end

  assign count_d = count_q + CW'(1);
  // A start in the same cycle wins over an offered vector, which is dropped.
  assign accept  = (state_q == COLLECT) && bc_change_valid && !bc_start;

  // NOTE: every state register below uses non-blocking assignments so all of
  // them update together from the values seen before the clock edge.
  always_ff @(posedge bc_clock or posedge bc_reset) begin
    if (bc_reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      target_q <= '0;
      // NOTE: the accumulators are reset explicitly because the outputs read
      // them directly and must show 0.0 as soon as reset is asserted.
      for (int k = 0; k < N_INPUTS; k++) acc_q[k] <= 0.0;
    end else if (bc_start) begin
      count_q  <= '0;
      target_q <= target_d;
      for (int k = 0; k < N_INPUTS; k++) acc_q[k] <= 0.0;
      state_q  <= (target_d == '0) ? DONE : COLLECT;
    end else if (accept) begin
      for (int k = 0; k < N_INPUTS; k++) begin
        if (bc_enabled[k]) acc_q[k] <= acc_q[k] + bc_change[k];
      end
      count_q <= count_d;
      if (count_d == target_q) state_q <= DONE;
    end else begin
      case (state_q)
        IDLE, COLLECT, DONE: state_q <= state_q;
        default:             state_q <= IDLE;
      endcase
    end
  end

  // Handshake and status flags decode the state register only.
  assign bc_change_ready = (state_q == COLLECT);
  assign bc_busy         = (state_q == COLLECT);
  assign bc_done         = (state_q == DONE);
  assign bc_count        = count_q;

  always_comb begin
    for (int k = 0; k < N_INPUTS; k++) bc_backprop[k] = acc_q[k];
  end

endmodule

// File: tb/tb_backprop_collector.sv
// Scoreboard bench for backprop_collector: a behavioural model queues the
// expected final sums, which are compared when the DUT raises bc_done.
module tb_backprop_collector;

  localparam int NI = 32;
  localparam int NS = 8;
  localparam int CW = 4;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic [CW-1:0] num   = '0;
  logic [NI-1:0] en    = '1;
  real           chg [NI-1:0];
  real           bp  [NI-1:0];
  logic          ready;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  backprop_collector #(.N_INPUTS(NI), .N_SOURCES(NS), .CW(CW)) dut (
    .bc_clock        (clk),
    .bc_reset        (rst),
    .bc_start        (start),
    .bc_num_sources  (num),
    .bc_enabled      (en),
    .bc_change_valid (valid),
    .bc_change       (chg),
    .bc_change_ready (ready),
    .bc_backprop     (bp),
    .bc_count        (count),
    .bc_busy         (busy),
    .bc_done         (done)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  real exp_q [$];
  real m_acc [NI];
  int  m_count  = 0;
  int  m_target = 0;
  int  m_state  = 0;  // 0 idle, 1 collect, 2 done
  logic prev_done = 1'b0;

  task automatic check(input string tag, input real got, input real exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %g, expected %g", tag, got, exp);
    end
  endtask

  task automatic push_expect();
    exp_q.push_back(real'(m_count));
    for (int k = 0; k < NI; k++) exp_q.push_back(m_acc[k]);
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_count  = 0;
    m_target = 0;
    for (int k = 0; k < NI; k++) m_acc[k] = 0.0;
  endtask

  task automatic clear_change();
    for (int k = 0; k < NI; k++) chg[k] = 0.0;
  endtask

  // Advance one clock: update the model from the driven inputs, then sample
  // the DUT one time unit after the edge.
  task automatic step();
    if (start) begin
      m_count  = 0;
      m_target = (int'(num) > NS) ? NS : int'(num);
      for (int k = 0; k < NI; k++) m_acc[k] = 0.0;
      m_state  = (m_target == 0) ? 2 : 1;
      if (m_state == 2) push_expect();
    end else if (m_state == 1 && valid) begin
      for (int k = 0; k < NI; k++) if (en[k]) m_acc[k] = m_acc[k] + chg[k];
      m_count++;
      if (m_count == m_target) begin
        m_state = 2;
        push_expect();
      end
    end
    @(posedge clk);
    #1;
    check("ready", ready, (m_state == 1) ? 1.0 : 0.0);
    check("busy",  busy,  (m_state == 1) ? 1.0 : 0.0);
    check("done",  done,  (m_state == 2) ? 1.0 : 0.0);
    check("count", count, real'(m_count));
    if (done && !prev_done) begin
      if (exp_q.size() < NI + 1) begin
        check("sb_unexpected_done", 1.0, 0.0);
      end else begin
        check("sb_count", count, exp_q.pop_front());
        for (int k = 0; k < NI; k++)
          check($sformatf("sb_lane%0d", k), bp[k], exp_q.pop_front());
      end
    end
    prev_done = done;
  endtask

  task automatic begin_epoch(input int n);
    num   = CW'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    clear_change();
    model_reset();

    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_ready", ready, 0.0);
    check("rst_busy",  busy,  0.0);
    check("rst_done",  done,  0.0);
    check("rst_count", count, 0.0);
    check("rst_lane0", bp[0], 0.0);
    @(negedge clk) rst = 1'b0;

    // Zero sources: done straight away, ready never high
    begin_epoch(0);
    check("zero_done", done, 1.0);
    for (int i = 0; i < 3; i++) step();

    // Basic sum on consecutive cycles
    begin_epoch(3);
    valid = 1'b1;
    chg[0] = 0.5;   chg[5] = 2.0; step();
    chg[0] = -0.25; chg[5] = 2.0; step();
    chg[0] = 1.0;   chg[5] = 2.0; step();
    valid = 1'b0;
    clear_change();
    check("basic_done",  done,  1.0);
    check("basic_count", count, 3.0);
    check("basic_l0",    bp[0], 1.25);
    check("basic_l5",    bp[5], 6.0);
    check("basic_l1",    bp[1], 0.0);

    // Stalled handshake with gaps, then valid in DONE is ignored
    begin_epoch(2);
    for (int i = 0; i < 3; i++) step();
    valid = 1'b1; chg[3] = 1.5;  step();
    valid = 1'b0;                step();
    valid = 1'b1; chg[3] = -0.5; step();
    chg[3] = 7.0;
    step();
    step();
    valid = 1'b0;
    clear_change();
    check("stall_count", count, 2.0);
    check("stall_l3",    bp[3], 1.0);

    // Lane mask
    en = 32'h0000_0001;
    begin_epoch(1);
    for (int k = 0; k < NI; k++) chg[k] = 1.0;
    valid = 1'b1; step();
    valid = 1'b0;
    clear_change();
    en = '1;
    check("mask_l0",  bp[0],  1.0);
    check("mask_l1",  bp[1],  0.0);
    check("mask_l31", bp[31], 0.0);

    // Clamp: 15 requested, only 8 accepted
    begin_epoch(15);
    valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chg[1] = real'(i + 1);
      chg[30] = $urandom_range(0, 100) / 4.0;
      step();
    end
    valid = 1'b0;
    clear_change();
    check("clamp_count", count, 8.0);
    check("clamp_l1",    bp[1], 36.0);

    // Abort mid-epoch with a simultaneous valid that must be dropped
    begin_epoch(3);
    valid = 1'b1; chg[2] = 4.0; step();
    start = 1'b1; chg[2] = 9.0; step();
    start = 1'b0; valid = 1'b0;
    check("abort_count", count, 0.0);
    check("abort_l2",    bp[2], 0.0);
    check("abort_busy",  busy,  1.0);
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chg[2] = 0.125 * real'(i + 1);
      step();
    end
    valid = 1'b0;
    clear_change();
    check("abort_l2_final", bp[2], 0.75);

    // Asynchronous reset between edges mid-collect
    begin_epoch(3);
    valid = 1'b1; chg[4] = 3.0; step();
    valid = 1'b0;
    clear_change();
    #3 rst = 1'b1;
    #1;
    check("areset_busy",  busy,  0.0);
    check("areset_ready", ready, 0.0);
    check("areset_count", count, 0.0);
    check("areset_l4",    bp[4], 0.0);
    model_reset();
    prev_done = 1'b0;
    @(negedge clk) rst = 1'b0;
    valid = 1'b1; chg[4] = 5.0;
    step();
    step();
    valid = 1'b0;
    clear_change();
    check("idle_l4", bp[4], 0.0);

    check("sb_empty", real'(exp_q.size()), 0.0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
